// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared state encoding, register offsets and CTRL field layout for the timer/counter
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Codes 10/11 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/tc_regs.sv
// rtl/tc_regs.sv - CTRL/PRESET storage, write decode and read mux for the timer/counter
// Optional byte-lane writes with TC_BYTE_WRITE_EN.
module tc_regs
  import tc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      din,
`ifdef TC_BYTE_WRITE_EN
  input  logic [3:0]       byteen,
`endif
  input  logic             en_clr,
  input  logic [CNT_W-1:0] count,
  output logic [3:0]       ctrl,
  output logic [CNT_W-1:0] preset,
  output logic             ctrl_wr,
  output logic             en_nxt,
  output logic [31:0]      dout
);

  logic [31:0] wmask;
  logic        wr_any;
  logic        preset_wr;
  logic [3:0]  ctrl_merged;
  logic [31:0] preset_word;
  logic [31:0] preset_merged;

`ifdef TC_BYTE_WRITE_EN
  assign wmask  = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign wr_any = we & (|byteen);
`else
  assign wmask  = '1;
  assign wr_any = we;
`endif

  assign ctrl_wr       = wr_any && (addr == OFF_CTRL);
  assign preset_wr     = wr_any && (addr == OFF_PRESET);
  assign ctrl_merged   = (ctrl & ~wmask[3:0]) | (din[3:0] & wmask[3:0]);
  assign preset_word   = 32'(preset);
  assign preset_merged = (preset_word & ~wmask) | (din & wmask);

  // EN as it will stand after this edge, so the FSM reacts in the same cycle as the CPU write.
  assign en_nxt = ctrl_wr ? ctrl_merged[CTRL_EN] : ctrl[CTRL_EN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl   <= '0;
      preset <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= ctrl_merged;
      end else if (en_clr) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      if (preset_wr) begin
        preset <= preset_merged[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      OFF_CTRL:   dout = {28'd0, ctrl};
      OFF_PRESET: dout = 32'(preset);
      OFF_COUNT:  dout = 32'(count);
      default:    dout = '0;
    endcase
  end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counting timer with one-shot and auto-reload IRQ
// Optional byteen port and byte-lane writes with TC_BYTE_WRITE_EN.
module timer_counter
  import tc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
`ifdef TC_BYTE_WRITE_EN
  input  logic [3:0]  byteen,
`endif
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e        state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             irq_flag, flag_set, flag_clr;
  logic             en_clr;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic             ctrl_wr;
  logic             en_nxt;
  logic             unused_bits;

  assign unused_bits = ^{Addr[31:4], ctrl[CTRL_EN]};

  tc_regs #(
    .CNT_W (CNT_W)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .addr    (Addr[3:2]),
    .we      (WE),
    .din     (Din),
`ifdef TC_BYTE_WRITE_EN
    .byteen  (byteen),
`endif
    .en_clr  (en_clr),
    .count   (count),
    .ctrl    (ctrl),
    .preset  (preset),
    .ctrl_wr (ctrl_wr),
    .en_nxt  (en_nxt),
    .dout    (Dout)
  );

  assign IRQ = irq_flag & ctrl[CTRL_IM];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A CPU write to CTRL always acknowledges, even if it lands on the terminal count.
      if (ctrl_wr || flag_clr) begin
        irq_flag <= 1'b0;
      end else if (flag_set) begin
        irq_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (en_nxt) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        flag_clr  = 1'b1;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en_nxt) begin
          state_nxt = IDLE;
        end else if (count > CNT_W'(1)) begin
          count_nxt = count - CNT_W'(1);
        end else begin
          count_nxt = '0;
          flag_set  = 1'b1;
          state_nxt = INT;
        end
      end
      INT: begin
        if (is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
          flag_clr  = 1'b1;
          state_nxt = LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed table-driven bench for timer_counter
// Byte-lane checks are compiled in with TC_BYTE_WRITE_EN.
module tb_timer_counter;

  localparam logic [31:2] BASE = 30'h1fc0;

  localparam logic [1:0] O_CTRL = 2'd0;
  localparam logic [1:0] O_PRE  = 2'd1;
  localparam logic [1:0] O_CNT  = 2'd2;
  localparam logic [1:0] O_RSV  = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] addr = BASE;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  byteen = 4'hf;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  off;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;
  } vec_t;

  vec_t tbl[26];
  logic [31:0] cyc_seq[5];

  timer_counter #(.CNT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (addr),
    .WE     (we),
    .Din    (din),
`ifdef TC_BYTE_WRITE_EN
    .byteen (byteen),
`endif
    .Dout   (dout),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, sample the combinational read 1ns later.
  task automatic step(input logic w, input logic [1:0] off, input logic [31:0] d,
                      input logic [3:0] be, input logic c, input logic [31:0] ed,
                      input logic ei, input string name);
    @(negedge clk);
    we     = w;
    addr   = BASE + {28'd0, off};
    din    = d;
    byteen = be;
    #1;
    if (c) begin
      chk({name, " dout"}, dout, ed);
      chk({name, " irq"}, {31'd0, irq}, {31'd0, ei});
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, O_PRE,  32'd5,      32'd0, 1'b0};
    tbl[1]  = '{1'b0, O_PRE,  32'd0,      32'd5, 1'b0};
    tbl[2]  = '{1'b1, O_CTRL, 32'h9,      32'd0, 1'b0};
    tbl[3]  = '{1'b0, O_CNT,  32'd0,      32'd0, 1'b0};
    tbl[4]  = '{1'b0, O_CNT,  32'd0,      32'd5, 1'b0};
    tbl[5]  = '{1'b0, O_CNT,  32'd0,      32'd4, 1'b0};
    tbl[6]  = '{1'b0, O_CNT,  32'd0,      32'd3, 1'b0};
    tbl[7]  = '{1'b0, O_CNT,  32'd0,      32'd2, 1'b0};
    tbl[8]  = '{1'b0, O_CNT,  32'd0,      32'd1, 1'b0};
    tbl[9]  = '{1'b0, O_CNT,  32'd0,      32'd0, 1'b1};
    tbl[10] = '{1'b0, O_CTRL, 32'd0,      32'h8, 1'b1};
    tbl[11] = '{1'b0, O_CTRL, 32'd0,      32'h8, 1'b1};
    tbl[12] = '{1'b1, O_CTRL, 32'h8,      32'h8, 1'b1};
    tbl[13] = '{1'b0, O_CTRL, 32'd0,      32'h8, 1'b0};
    tbl[14] = '{1'b1, O_CNT,  32'h1234,   32'd0, 1'b0};
    tbl[15] = '{1'b0, O_CNT,  32'd0,      32'd0, 1'b0};
    tbl[16] = '{1'b1, O_RSV,  32'h1234,   32'd0, 1'b0};
    tbl[17] = '{1'b0, O_RSV,  32'd0,      32'd0, 1'b0};
    tbl[18] = '{1'b1, O_PRE,  32'd0,      32'd5, 1'b0};
    tbl[19] = '{1'b1, O_CTRL, 32'h9,      32'h8, 1'b0};
    tbl[20] = '{1'b0, O_CNT,  32'd0,      32'd0, 1'b0};
    tbl[21] = '{1'b0, O_CNT,  32'd0,      32'd0, 1'b0};
    tbl[22] = '{1'b0, O_CTRL, 32'd0,      32'h9, 1'b1};
    tbl[23] = '{1'b0, O_CTRL, 32'd0,      32'h8, 1'b1};
    tbl[24] = '{1'b1, O_CTRL, 32'd0,      32'h8, 1'b1};
    tbl[25] = '{1'b0, O_CTRL, 32'd0,      32'd0, 1'b0};

    cyc_seq[0] = 32'd3;
    cyc_seq[1] = 32'd2;
    cyc_seq[2] = 32'd1;
    cyc_seq[3] = 32'd0;
    cyc_seq[4] = 32'd0;

    // Power-on reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int o = 0; o < 4; o++) step(1'b0, 2'(o), 32'd0, 4'hf, 1'b1, 32'd0, 1'b0, $sformatf("por off%0d", o));

    // Reset asserted with an IRQ pending
    step(1'b1, O_PRE,  32'd2, 4'hf, 1'b0, 32'd0, 1'b0, "rst pre");
    step(1'b1, O_CTRL, 32'h9, 4'hf, 1'b0, 32'd0, 1'b0, "rst ctrl");
    for (int k = 1; k <= 3; k++) step(1'b0, O_CNT, 32'd0, 4'hf, 1'b0, 32'd0, 1'b0, "rst run");
    step(1'b0, O_CNT, 32'd0, 4'hf, 1'b1, 32'd0, 1'b1, "rst pending");
    #2 reset = 1'b0;
    #1 chk("rst async irq", {31'd0, irq}, 32'd0);
    chk("rst async dout", dout, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int o = 0; o < 4; o++) step(1'b0, 2'(o), 32'd0, 4'hf, 1'b1, 32'd0, 1'b0, $sformatf("rst off%0d", o));

    // One-shot, IRQ clear, read-only/reserved writes, PRESET=0 timing
    for (int i = 0; i < 26; i++)
      step(tbl[i].we, tbl[i].off, tbl[i].din, 4'hf, 1'b1, tbl[i].dout, tbl[i].irq, $sformatf("vec%0d", i));

    // Auto-reload: 1-cycle pulse every PRESET+2 cycles
    step(1'b1, O_PRE,  32'd3, 4'hf, 1'b1, 32'd0, 1'b0, "ar pre");
    step(1'b1, O_CTRL, 32'hb, 4'hf, 1'b1, 32'd0, 1'b0, "ar ctrl");
    for (int k = 1; k <= 20; k++)
      step(1'b0, O_CTRL, 32'd0, 4'hf, 1'b1, 32'hb, (k % 5) == 0, $sformatf("ar k%0d", k));
    step(1'b1, O_CTRL, 32'h3, 4'hf, 1'b1, 32'hb, 1'b0, "ar mask");
    for (int j = 1; j <= 10; j++)
      step(1'b0, O_CNT, 32'd0, 4'hf, 1'b1, cyc_seq[(j - 1) % 5], 1'b0, $sformatf("ar masked j%0d", j));
    step(1'b1, O_CTRL, 32'd0, 4'hf, 1'b1, 32'h3, 1'b0, "ar stop");

    // Pause holds COUNT, re-enable reloads
    step(1'b1, O_PRE,  32'd10, 4'hf, 1'b1, 32'd3, 1'b0, "ps pre");
    step(1'b1, O_CTRL, 32'h1,  4'hf, 1'b1, 32'd0, 1'b0, "ps ctrl");
    step(1'b0, O_CNT,  32'd0,  4'hf, 1'b1, 32'd3, 1'b0, "ps load");
    for (int j = 2; j <= 5; j++)
      step(1'b0, O_CNT, 32'd0, 4'hf, 1'b1, 32'(12 - j), 1'b0, $sformatf("ps j%0d", j));
    step(1'b1, O_CTRL, 32'h0, 4'hf, 1'b1, 32'h1, 1'b0, "ps clr en");
    for (int j = 0; j < 3; j++)
      step(1'b0, O_CNT, 32'd0, 4'hf, 1'b1, 32'd6, 1'b0, $sformatf("ps hold%0d", j));
    step(1'b1, O_CTRL, 32'h1, 4'hf, 1'b1, 32'h0, 1'b0, "ps set en");
    step(1'b0, O_CNT,  32'd0, 4'hf, 1'b1, 32'd6,  1'b0, "ps reload0");
    step(1'b0, O_CNT,  32'd0, 4'hf, 1'b1, 32'd10, 1'b0, "ps reload1");
    step(1'b0, O_CNT,  32'd0, 4'hf, 1'b1, 32'd9,  1'b0, "ps reload2");
    step(1'b1, O_CTRL, 32'd0, 4'hf, 1'b0, 32'd0,  1'b0, "ps off");

`ifdef TC_BYTE_WRITE_EN
    step(1'b1, O_PRE, 32'haabbccdd, 4'hf,    1'b0, 32'd0, 1'b0, "be full");
    step(1'b1, O_PRE, 32'h11223344, 4'b0101, 1'b1, 32'haabbccdd, 1'b0, "be part");
    step(1'b0, O_PRE, 32'd0,        4'hf,    1'b1, 32'haa22cc44, 1'b0, "be merged");
    step(1'b1, O_PRE, 32'hffffffff, 4'h0,    1'b0, 32'd0, 1'b0, "be none");
    step(1'b0, O_PRE, 32'd0,        4'hf,    1'b1, 32'haa22cc44, 1'b0, "be noop");
`endif

    step(1'b0, O_CTRL, 32'd0, 4'hf, 1'b0, 32'd0, 1'b0, "end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
